// File: rtl/midi_voice_alloc_pkg.sv
// Shared types for the MIDI voice allocator: FSM state encoding, the latched
// note event record and the velocity used when a zero-velocity note-on becomes a release.
package synth_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } alloc_state_t;

  typedef struct packed {
    logic       on;
    logic [6:0] key;
    logic [7:0] vel;
  } note_evt_t;

  localparam logic [7:0] REL_OFF_VEL = 8'd64;

  // MIDI running-status idiom: note-on with velocity 0 means note-off
  function automatic note_evt_t normalise_on(input logic [6:0] key, input logic [7:0] vel);
    note_evt_t evt;
    evt.on  = (vel != 8'd0);
    evt.key = key;
    evt.vel = (vel == 8'd0) ? REL_OFF_VEL : vel;
    return evt;
  endfunction

endpackage

// File: rtl/midi_voice_alloc_if.sv
// Event/key-state bundle between the MIDI decoder side (master) and the
// voice allocator (slave); voice_free comes from the envelope generators.
interface midi_voice_alloc_if #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
);
  logic               on_stb;
  logic               off_stb;
  logic               all_off;
  logic [6:0]         key_in;
  logic [7:0]         vel_in;
  logic [VOICES-1:0]  voice_free;
  logic [VOICES-1:0]  keys_on;
  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic [7:0]         cur_vel_on;
  logic [7:0]         cur_vel_off;
  logic               event_stb;
  logic               busy;
  logic               ovf;

  modport master (
    output on_stb, off_stb, all_off, key_in, vel_in, voice_free,
    input  keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off,
           event_stb, busy, ovf
  );

  modport slave (
    input  on_stb, off_stb, all_off, key_in, vel_in, voice_free,
    output keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off,
           event_stb, busy, ovf
  );
endinterface

// File: rtl/midi_voice_alloc.sv
// Voice allocator: scans one voice per clock to find a retrigger, free or
// released voice for each note event, falling back to round-robin stealing.
module midi_voice_alloc
  import synth_alloc_pkg::*;
#(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input logic reg_clk,
  input logic reset_reg,
  midi_voice_alloc_if.slave bus
);

  alloc_state_t       state;
  note_evt_t          cur_evt;
  note_evt_t          pend_evt;
  logic               pend_full;
  logic [6:0]         ktab [VOICES];
  logic [VOICES-1:0]  keys_on;
  logic [V_WIDTH-1:0] idx;
  logic [V_WIDTH-1:0] steal_ptr;
  logic [V_WIDTH-1:0] match_idx, free_idx, rel_idx;
  logic               match_found, free_found, rel_found;

  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val, cur_vel_on, cur_vel_off;
  logic               event_stb, ovf;

  note_evt_t          first_evt, second_evt;
  logic               first_v, second_v;
  logic [V_WIDTH-1:0] tgt;
  logic               steal;

  // A simultaneous off/on pair is ordered off first
  always_comb begin
    first_v    = 1'b0;
    second_v   = 1'b0;
    first_evt  = '0;
    second_evt = '0;
    if (bus.off_stb) begin
      first_v    = 1'b1;
      first_evt  = '{on: 1'b0, key: bus.key_in, vel: bus.vel_in};
      second_v   = bus.on_stb;
      second_evt = normalise_on(bus.key_in, bus.vel_in);
    end else if (bus.on_stb) begin
      first_v    = 1'b1;
      first_evt  = normalise_on(bus.key_in, bus.vel_in);
    end
  end

  always_comb begin
    tgt   = steal_ptr;
    steal = 1'b0;
    if (match_found)     tgt = match_idx;
    else if (free_found) tgt = free_idx;
    else if (rel_found)  tgt = rel_idx;
    else                 steal = 1'b1;
  end

  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      state       <= IDLE;
      cur_evt     <= '0;
      pend_evt    <= '0;
      pend_full   <= 1'b0;
      keys_on     <= '0;
      idx         <= '0;
      steal_ptr   <= '0;
      match_idx   <= '0;
      free_idx    <= '0;
      rel_idx     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      event_stb   <= 1'b0;
      ovf         <= 1'b0;
      for (int i = 0; i < VOICES; i++) ktab[i] <= '0;
    end else if (bus.all_off) begin
      state     <= IDLE;
      keys_on   <= '0;
      pend_full <= 1'b0;
      event_stb <= 1'b0;
    end else begin
      event_stb <= 1'b0;
      if (state == IDLE) begin
        if (pend_full || first_v) begin
          state       <= SCAN;
          idx         <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          rel_found   <= 1'b0;
        end
        if (pend_full) begin
          cur_evt   <= pend_evt;
          pend_evt  <= first_evt;
          pend_full <= first_v;
          if (second_v) ovf <= 1'b1;
        end else if (first_v) begin
          cur_evt   <= first_evt;
          pend_evt  <= second_evt;
          pend_full <= second_v;
        end
      end else begin
        // The second of a pair can never find the slot empty while busy
        if (first_v) begin
          if (!pend_full) begin
            pend_evt  <= first_evt;
            pend_full <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end
        if (second_v) ovf <= 1'b1;
      end

      if (state == SCAN) begin
        if (keys_on[idx] && (ktab[idx] == cur_evt.key) && !match_found) begin
          match_found <= 1'b1;
          match_idx   <= idx;
        end
        if (!keys_on[idx] && bus.voice_free[idx] && !free_found) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
        if (!keys_on[idx] && !rel_found) begin
          rel_found <= 1'b1;
          rel_idx   <= idx;
        end
        if (idx == V_WIDTH'(VOICES - 1)) state <= EMIT;
        else                             idx   <= idx + 1'b1;
      end

      if (state == EMIT) begin
        state <= IDLE;
        if (cur_evt.on) begin
          keys_on[tgt] <= 1'b1;
          ktab[tgt]    <= cur_evt.key;
          note_on      <= 1'b1;
          cur_key_adr  <= tgt;
          cur_key_val  <= {1'b0, cur_evt.key};
          cur_vel_on   <= cur_evt.vel;
          event_stb    <= 1'b1;
          if (steal)
            steal_ptr <= (steal_ptr == V_WIDTH'(VOICES - 1)) ? '0 : steal_ptr + 1'b1;
        end else if (match_found) begin
          keys_on[match_idx] <= 1'b0;
          note_on            <= 1'b0;
          cur_key_adr        <= match_idx;
          cur_key_val        <= {1'b0, cur_evt.key};
          cur_vel_off        <= cur_evt.vel;
          event_stb          <= 1'b1;
        end
      end
    end
  end

  assign bus.keys_on     = keys_on;
  assign bus.note_on     = note_on;
  assign bus.cur_key_adr = cur_key_adr;
  assign bus.cur_key_val = cur_key_val;
  assign bus.cur_vel_on  = cur_vel_on;
  assign bus.cur_vel_off = cur_vel_off;
  assign bus.event_stb   = event_stb;
  assign bus.busy        = (state != IDLE);
  assign bus.ovf         = ovf;

endmodule
